// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  // Arbiter FSM: IDLE accepts host requests, ACK is the one-cycle completion slot.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  localparam int DEFAULT_STARVE_LIMIT = 8;

  // Width needed to hold a starvation counter that saturates at 'limit'.
  function automatic int wait_cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and active-low synchronous reset.
module sat_counter #(
  parameter int           W     = 8,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise step up until LIMIT is reached.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != LIMIT)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store port and a
// host port. The core wins by default; a host starved for STARVE_LIMIT cycles
// gets a forced slot that stalls the core for exactly one cycle.
//
// Host handshake: the host raises host_req with host_we/host_addr/host_wdata
// and holds them stable until host_ack. The access is granted in some IDLE
// cycle (same cycle, combinationally onto the memory); host_ack pulses for one
// cycle on the following cycle with host_rdata valid for reads. During the ack
// cycle host_req is ignored, giving the host one cycle to drop or change it.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_memwrite,
  input  logic          cpu_memread,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] stall_count,
  output state_e        dbg_state
);

  localparam int             WCW      = wait_cnt_width(STARVE_LIMIT);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(STARVE_LIMIT);

  state_e          state_q, state_d;
  logic [DW-1:0]   host_rdata_q, host_rdata_d;
  logic [WCW-1:0]  wait_cnt;
  logic            cpu_access;
  logic            host_grant;
  logic            wait_inc;
  logic            wait_clr;

  assign cpu_access = cpu_memwrite | cpu_memread;

  // Next-state and grant: host only wins in IDLE, on a free cycle or once starved.
  always_comb begin
    state_d    = state_q;
    host_grant = 1'b0;
    case (state_q)
      IDLE: begin
        host_grant = host_req & (~cpu_access | (wait_cnt == WAIT_LIM));
        if (host_grant) begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Host read data is captured in the grant cycle and held otherwise.
  always_comb begin
    host_rdata_d = host_rdata_q;
    if (host_grant && !host_we) begin
      host_rdata_d = mem_rdata;
    end
  end

  // State and host read-data registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Starvation tracking: counts IDLE cycles where the host was blocked by the core.
  // It is already zero in ACK because the grant cleared it, so ACK holds it at 0.
  assign wait_inc = (state_q == IDLE) & host_req & cpu_access & ~host_grant;
  assign wait_clr = ~host_req | host_grant;

  sat_counter #(
    .W     (WCW),
    .LIMIT (WAIT_LIM)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wait_inc),
    .clear (wait_clr),
    .count (wait_cnt)
  );

  // Forced-stall statistics, saturating at all-ones.
  sat_counter #(
    .W     (CW),
    .LIMIT ({CW{1'b1}})
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cpu_stall),
    .clear (1'b0),
    .count (stall_count)
  );

  // Memory mux; writes and stalls are suppressed while reset is held low.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = reset & cpu_memwrite;
    if (host_grant) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = reset & host_we;
    end
  end

  assign cpu_stall  = reset & host_grant & cpu_access;
  assign cpu_rdata  = mem_rdata;
  assign host_rdata = host_rdata_q;
  assign host_ack   = (state_q == ACK);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        cpu_memwrite, cpu_memread;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        host_req, host_we;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        host_ack;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] stall_count;
  state_e      dbg_state;

  // Second instance with a 4-bit stall counter, same stimulus.
  logic [31:0] cpu_rdata2, host_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
  logic        cpu_stall2, host_ack2, mem_we2;
  logic [3:0]  stall_count2;
  state_e      dbg_state2;

  logic [31:0] mem [0:255];

  assign mem_rdata  = mem[mem_addr[9:2]];
  assign mem_rdata2 = mem[mem_addr2[9:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(8), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_count(stall_count), .dbg_state(dbg_state)
  );

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(8), .CW(4)) dut_sat (
    .clk(clk), .reset(reset),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata2),
    .cpu_stall(cpu_stall2),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata2), .host_ack(host_ack2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .stall_count(stall_count2), .dbg_state(dbg_state2)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    cpu_memwrite = 1'b0;
    cpu_memread  = 1'b0;
    cpu_addr     = 32'h0;
    cpu_wdata    = 32'h0;
  endtask

  task automatic host_set(input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    host_req   = req;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seen;
    int cyc;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h40 >> 2] = 32'hDEADBEEF;

    // Reset with a core store and host write pending: nothing may commit.
    reset = 1'b0;
    cpu_memwrite = 1'b1; cpu_memread = 1'b0;
    cpu_addr = 32'h40; cpu_wdata = 32'h12345678;
    host_set(1'b1, 1'b1, 32'h40, 32'h87654321);
    tick();
    tick();
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_mem_intact", mem[32'h40 >> 2], 32'hDEADBEEF);

    core_idle();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();

    // Free-slot host read of 0x40.
    host_set(1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("free_mem_addr", mem_addr, 32'h40);
    chk("free_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("free_mem_we", 32'(mem_we), 32'd0);
    chk("free_ack_early", 32'(host_ack), 32'd0);
    tick();
    chk("free_ack", 32'(host_ack), 32'd1);
    chk("free_rdata", host_rdata, 32'hDEADBEEF);
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("free_ack_pulse", 32'(host_ack), 32'd0);

    // Core stores every cycle; host write 0x80=0x11 waits 8 cycles then forces a slot.
    cpu_memwrite = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h55;
    host_set(1'b1, 1'b1, 32'h80, 32'h11);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("prio_blocked_stall_%0d", k), 32'(cpu_stall), 32'd0);
      chk($sformatf("prio_blocked_addr_%0d", k), mem_addr, 32'h100);
      tick();
    end
    #1;
    chk("prio_force_stall", 32'(cpu_stall), 32'd1);
    chk("prio_force_we", 32'(mem_we), 32'd1);
    chk("prio_force_addr", mem_addr, 32'h80);
    chk("prio_force_wdata", mem_wdata, 32'h11);
    tick();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("prio_ack", 32'(host_ack), 32'd1);
    chk("prio_stall_count", 32'(stall_count), 32'd1);
    chk("prio_mem_80", mem[32'h80 >> 2], 32'h11);
    chk("prio_ack_core_runs", 32'(cpu_stall), 32'd0);
    chk("prio_ack_core_addr", mem_addr, 32'h100);
    tick();
    core_idle();

    // Same-address conflict: forced host write 0x10=0xAA vs core store 0x10=0xBB.
    cpu_memread = 1'b1; cpu_addr = 32'h40;
    host_set(1'b1, 1'b1, 32'h10, 32'hAA);
    #1;
    chk("conf_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    for (int k = 0; k < 8; k++) tick();
    cpu_memread = 1'b0; cpu_memwrite = 1'b1;
    cpu_addr = 32'h10; cpu_wdata = 32'hBB;
    #1;
    chk("conf_stall", 32'(cpu_stall), 32'd1);
    chk("conf_host_wdata", mem_wdata, 32'hAA);
    tick();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("conf_mem_host_first", mem[32'h10 >> 2], 32'hAA);
    chk("conf_ack", 32'(host_ack), 32'd1);
    chk("conf_rdata_held", host_rdata, 32'hDEADBEEF);
    chk("conf_core_reissue_we", 32'(mem_we), 32'd1);
    chk("conf_core_reissue_wdata", mem_wdata, 32'hBB);
    tick();
    core_idle();
    chk("conf_mem_core_last", mem[32'h10 >> 2], 32'hBB);
    chk("conf_stall_count", 32'(stall_count), 32'd2);

    // Back-to-back host reads with req held high through ACK.
    cpu_addr = 32'h300;
    host_set(1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("b2b_grant1_addr", mem_addr, 32'h40);
    tick();
    host_addr = 32'h80;
    #1;
    chk("b2b_ack1", 32'(host_ack), 32'd1);
    chk("b2b_rdata1", host_rdata, 32'hDEADBEEF);
    chk("b2b_no_grant_in_ack", mem_addr, 32'h300);
    tick();
    chk("b2b_ack_gap", 32'(host_ack), 32'd0);
    chk("b2b_grant2_addr", mem_addr, 32'h80);
    tick();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("b2b_ack2", 32'(host_ack), 32'd1);
    chk("b2b_rdata2", host_rdata, 32'h11);
    tick();
    chk("b2b_ack2_pulse", 32'(host_ack), 32'd0);

    // Saturation: 20 more forced stalls; the 4-bit counter stops at 15.
    chk("sat_pre_small", 32'(stall_count2), 32'd2);
    cpu_memread = 1'b1; cpu_addr = 32'h40;
    host_set(1'b1, 1'b0, 32'h40, 32'h0);
    seen = 0;
    cyc  = 0;
    while (seen < 20 && cyc < 400) begin
      @(negedge clk);
      if (cpu_stall) seen++;
      cyc++;
    end
    chk("sat_stalls_seen", 32'(seen), 32'd20);
    tick();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    core_idle();
    #1;
    chk("sat_ack", 32'(host_ack), 32'd1);
    chk("sat_count_wide", 32'(stall_count), 32'd22);
    chk("sat_count_small", 32'(stall_count2), 32'd15);
    tick();

    // Reset during the ACK cycle drops the pending transaction.
    host_set(1'b1, 1'b0, 32'h80, 32'h0);
    tick();
    #1;
    chk("rack_ack_before", 32'(host_ack), 32'd1);
    chk("rack_rdata_before", host_rdata, 32'h11);
    reset = 1'b0;
    cpu_memwrite = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'h77;
    #1;
    chk("rack_mem_we", 32'(mem_we), 32'd0);
    chk("rack_cpu_stall", 32'(cpu_stall), 32'd0);
    tick();
    chk("rack_ack_dropped", 32'(host_ack), 32'd0);
    chk("rack_stall_count", 32'(stall_count), 32'd0);
    chk("rack_stall_count_small", 32'(stall_count2), 32'd0);
    chk("rack_rdata", host_rdata, 32'h0);
    chk("rack_no_write", mem[32'h200 >> 2], 32'h0);
    reset = 1'b1;
    core_idle();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("rack_after_ack", 32'(host_ack), 32'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the ARM core's load/store port and an external host port (loader/monitor/debug) with a req/ack handshake.
- Core has priority. Host uses free cycles, i.e. cycles with no core load/store.
- If the host starves for STARVE_LIMIT cycles, the arbiter stalls the core for one cycle and forces a host slot.
- Sits between core (MemWrite, MemtoReg, ALUResult, WriteData, ReadData) and dmem (combinational read, write on clk edge).

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 8, consecutive blocked host cycles before a forced slot (>=1)
- CW, 16, width of stall statistics counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cpu_memwrite  in  1  core store this cycle (MemWrite)
- cpu_memread  in  1  core load this cycle (MemtoReg)
- cpu_addr  in  AW  core address (ALUResult)
- cpu_wdata  in  DW  core store data (WriteData)
- cpu_rdata  out  DW  load data to core (ReadData)
- cpu_stall  out  1  core clock-enable kill: PC/regfile must not update
- host_req  in  1  host request, held stable until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_rdata  out  DW  registered host read data, valid with host_ack
- host_ack  out  1  one-cycle completion pulse
- mem_we  out  1  dmem write enable
- mem_addr  out  AW  dmem address
- mem_wdata  out  DW  dmem write data
- mem_rdata  in  DW  dmem combinational read data
- stall_count  out  CW  saturating count of forced-stall cycles

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, wait_cnt=0, host_ack=0, host_rdata=0, stall_count=0.
  - While reset==0: mem_we=0 and cpu_stall=0, so no write commits during reset.
- cpu_access = cpu_memwrite | cpu_memread.
- FSM states:
  - IDLE: accept host requests.
  - ACK: host_ack=1 this cycle; host_req ignored; next state always IDLE. This guarantees one dead cycle so the host can drop req.
- Grant in IDLE (combinational, same cycle):
  - host_grant = host_req & (!cpu_access | wait_cnt==STARVE_LIMIT).
  - cpu_stall = host_grant & cpu_access.
- Memory mux:
  - host_grant=1: mem_addr=host_addr, mem_wdata=host_wdata, mem_we=host_we.
  - Otherwise: core fields drive the memory, mem_we=cpu_memwrite.
  - cpu_rdata = mem_rdata always. The core ignores it while stalled and reissues the access next cycle.
- On a host_grant edge:
  - state goes to ACK.
  - host_rdata <= mem_rdata when host_we=0; host_rdata is held when host_we=1.
  - wait_cnt <= 0.
- Latency: host_ack asserts exactly 1 cycle after the grant cycle. Minimum host request-to-ack is 1 cycle; maximum is STARVE_LIMIT+1 cycles.
- wait_cnt:
  - Increments (saturating at STARVE_LIMIT) in IDLE when host_req & cpu_access & !host_grant.
  - Cleared when host_req=0.
  - Held in ACK.
- stall_count increments on every cpu_stall cycle and saturates at all-ones.
- Forced-slot stall length is exactly 1 cycle. In the following cycle (ACK) the core access proceeds unconditionally.
- Simultaneous write to the same address (core store blocked by a host grant): the host write commits first. The core store commits in the next cycle, so the final value is the core value.
- host_req dropped before ack: protocol violation. The arbiter behaves combinationally on the current inputs; no assertion is required beyond a bench check.
- Reset mid-ACK: host_ack drops at the reset edge; the pending host transaction is lost. The host must re-request.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum {IDLE, ACK}.
  - Default STARVE_LIMIT.
- Sub-module sat_counter (parameterised width/limit, inc/clear): used for wait_cnt and stall_count.
- Mux, FSM and grant logic stay in dmem_arbiter.

Test Plan:
- Reset mid-ACK: reset low during the ACK cycle -> host_ack=0 next cycle, stall_count=0, mem_we=0 while reset low.
- Free-slot read: core idle, host read 0x40 where mem holds 0xDEADBEEF -> cycle N mem_addr=0x40, cpu_stall=0; cycle N+1 host_ack=1, host_rdata=0xDEADBEEF.
- Core priority: core stores every cycle; host write 0x80=0x11 with STARVE_LIMIT=8 -> 8 blocked cycles, then 1 cycle with cpu_stall=1 and mem_we=1, mem_addr=0x80; ack 1 cycle later; stall_count=1.
- Same-address conflict: forced host write 0x10=0xAA while core stores 0x10=0xBB -> memory 0xAA after the stall cycle, 0xBB one cycle later; core store not lost.
- Back-to-back host requests with req held high through ACK -> no grant in the ACK cycle; second grant no earlier than the cycle after ACK; two distinct single-cycle acks.
- stall_count saturation: CW=4, 20 forced stalls -> stall_count=15.
